// File: rtl/universal_shift_register.sv
// Universal shift register with a burst sequencer.
//
// In IDLE each enabled edge applies mode_i directly to the register.
// A start request with a non-zero count captures mode_i. The block then
// repeats that operation count times, one per enabled edge, and raises
// done for one cycle on the edge that completes the last operation.
// A start with count=0 does no operation and only pulses done.
//
// Ports:
//   clk_i           sole clock, rising edge
//   rst_i           asynchronous active-high reset
//   en_i            clock enable; 0 freezes q, burst state and serial_out
//   mode_i[2:0]     000 HOLD, 001 LOAD, 010 SHL, 011 SHR,
//                   100 ROL, 101 ROR, 110 ASR, 111 CLR
//   parallel_in_i   load data
//   serial_in_i     bits entering on SHL (at LSBs) or SHR (at MSBs)
//   start_i         burst request (sampled in IDLE only)
//   count_i         burst length (sampled in IDLE only)
//   parallel_out_o  register contents
//   serial_out_o    bits ejected by the most recent shift/rotate
//   busy_o          burst in progress
//   done_o          one-cycle burst-complete pulse
//   state_o         debug view of the sequencer state (1 = BUSY)
//
// Handshake: start_i is taken on an enabled edge while busy_o=0 (including
// the cycle in which done_o is high); start_i, count_i and mode_i are
// ignored while busy_o=1.
module universal_shift_register #(
    parameter int WIDTH = 8,
    parameter int STEP  = 1,
    parameter int CNT_W = 4
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             en_i,
    input  logic [2:0]       mode_i,
    input  logic [WIDTH-1:0] parallel_in_i,
    input  logic [STEP-1:0]  serial_in_i,
    input  logic             start_i,
    input  logic [CNT_W-1:0] count_i,
    output logic [WIDTH-1:0] parallel_out_o,
    output logic [STEP-1:0]  serial_out_o,
    output logic             busy_o,
    output logic             done_o,
    output logic             state_o
);

    localparam logic [2:0] M_HOLD = 3'b000;
    localparam logic [2:0] M_LOAD = 3'b001;
    localparam logic [2:0] M_SHL  = 3'b010;
    localparam logic [2:0] M_SHR  = 3'b011;
    localparam logic [2:0] M_ROL  = 3'b100;
    localparam logic [2:0] M_ROR  = 3'b101;
    localparam logic [2:0] M_ASR  = 3'b110;
    localparam logic [2:0] M_CLR  = 3'b111;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] rem_q, rem_d;
    logic [2:0]       mode_q, mode_d;
    logic [WIDTH-1:0] q_q, q_d;
    logic [STEP-1:0]  so_q, so_d;
    logic             done_q, done_d;

    // Result of the selected operation on the current register.
    logic [2:0]       op_sel;
    logic [WIDTH-1:0] op_q;
    logic [STEP-1:0]  op_so;

    // During a burst the captured mode drives the datapath; otherwise
    // the live mode input does.
    always_comb begin
        op_sel = (state_q == BUSY) ? mode_q : mode_i;
        op_q   = q_q;
        op_so  = so_q;
        case (op_sel)
            M_HOLD: op_q = q_q;
            M_LOAD: op_q = parallel_in_i;
            M_SHL: begin
                op_q  = {q_q[WIDTH-STEP-1:0], serial_in_i};
                op_so = q_q[WIDTH-1 -: STEP];
            end
            M_SHR: begin
                op_q  = {serial_in_i, q_q[WIDTH-1:STEP]};
                op_so = q_q[STEP-1:0];
            end
            M_ROL: begin
                op_q  = {q_q[WIDTH-STEP-1:0], q_q[WIDTH-1 -: STEP]};
                op_so = q_q[WIDTH-1 -: STEP];
            end
            M_ROR: begin
                op_q  = {q_q[STEP-1:0], q_q[WIDTH-1:STEP]};
                op_so = q_q[STEP-1:0];
            end
            M_ASR: begin
                op_q  = {{STEP{q_q[WIDTH-1]}}, q_q[WIDTH-1:STEP]};
                op_so = q_q[STEP-1:0];
            end
            M_CLR: op_q = '0;
        endcase
    end

    always_comb begin
        state_d = state_q;
        rem_d   = rem_q;
        mode_d  = mode_q;
        q_d     = q_q;
        so_d    = so_q;
        // done is a pulse: it drops on the next edge whether or not en_i is set.
        done_d  = 1'b0;
        if (en_i) begin
            case (state_q)
                IDLE: begin
                    if (start_i) begin
                        if (count_i != '0) begin
                            state_d = BUSY;
                            rem_d   = count_i;
                            mode_d  = mode_i;
                        end else begin
                            done_d = 1'b1;
                        end
                    end else begin
                        q_d  = op_q;
                        so_d = op_so;
                    end
                end
                BUSY: begin
                    q_d   = op_q;
                    so_d  = op_so;
                    // rem is at least 1 in BUSY, so this cannot wrap.
                    rem_d = rem_q - CNT_W'(1);
                    if (rem_q == CNT_W'(1)) begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            rem_q   <= '0;
            mode_q  <= M_HOLD;
            q_q     <= '0;
            so_q    <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            rem_q   <= rem_d;
            mode_q  <= mode_d;
            q_q     <= q_d;
            so_q    <= so_d;
            done_q  <= done_d;
        end
    end

    assign parallel_out_o = q_q;
    assign serial_out_o   = so_q;
    assign busy_o         = (state_q == BUSY);
    assign done_o         = done_q;
    assign state_o        = state_q;

endmodule

// File: tb/tb_universal_shift_register.sv
// Bench for universal_shift_register: an 8-bit STEP=1 instance and an 8-bit
// STEP=2 instance share all control inputs. A behavioural model tracks both,
// and a negedge process compares every output each cycle. Directed sequences
// add literal expectations.
module tb_universal_shift_register;
  localparam int HOLD = 0, LOAD = 1, SHL = 2, SHR = 3, ROL = 4, ROR = 5, ASR = 6, CLR = 7;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en = 1'b0;
  logic [2:0] mode = '0;
  logic [7:0] pin = '0;
  logic       sin1 = 1'b0;
  logic [1:0] sin2 = '0;
  logic       start = 1'b0;
  logic [3:0] count = '0;

  logic [7:0] pout1, pout2;
  logic       sout1;
  logic [1:0] sout2;
  logic       busy1, busy2, done1, done2, st1, st2;

  int n_checks = 0;
  int n_errors = 0;
  bit chk_on = 1'b0;

  always #5 clk = ~clk;

  universal_shift_register #(.WIDTH(8), .STEP(1), .CNT_W(4)) dut1 (
    .clk_i(clk), .rst_i(rst), .en_i(en), .mode_i(mode), .parallel_in_i(pin),
    .serial_in_i(sin1), .start_i(start), .count_i(count),
    .parallel_out_o(pout1), .serial_out_o(sout1), .busy_o(busy1),
    .done_o(done1), .state_o(st1)
  );

  universal_shift_register #(.WIDTH(8), .STEP(2), .CNT_W(4)) dut2 (
    .clk_i(clk), .rst_i(rst), .en_i(en), .mode_i(mode), .parallel_in_i(pin),
    .serial_in_i(sin2), .start_i(start), .count_i(count),
    .parallel_out_o(pout2), .serial_out_o(sout2), .busy_o(busy2),
    .done_o(done2), .state_o(st2)
  );

  // ---------------- behavioural model ----------------
  int m_q[2]  = '{0, 0};
  int m_so[2] = '{0, 0};
  int m_busy = 0, m_done = 0, m_rem = 0, m_op = 0;

  function automatic int model_q(input int op, input int q, input int s, input int sin, input int p);
    int v;
    case (op)
      LOAD: return p;
      SHL:  return ((q << s) | sin) & 255;
      SHR:  return (q >> s) | (sin << (8 - s));
      ROL:  return ((q << s) | (q >> (8 - s))) & 255;
      ROR:  return ((q >> s) | (q << (8 - s))) & 255;
      ASR: begin
        v = (q >= 128) ? q - 256 : q;
        v = v >>> s;
        return v & 255;
      end
      CLR:  return 0;
      default: return q;
    endcase
  endfunction

  function automatic int model_so(input int op, input int q, input int s, input int old);
    case (op)
      SHL, ROL:      return q >> (8 - s);
      SHR, ROR, ASR: return q & ((1 << s) - 1);
      default:       return old;
    endcase
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 2; i++) begin
        m_q[i]  <= 0;
        m_so[i] <= 0;
      end
      m_busy <= 0;
      m_done <= 0;
      m_rem  <= 0;
    end else begin
      int  op, nb, nr, nop, nd;
      bit  do_op;
      nb = m_busy; nr = m_rem; nop = m_op; nd = 0; do_op = 0; op = 0;
      if (en) begin
        if (m_busy == 0) begin
          if (start) begin
            if (count != 0) begin
              nb = 1; nr = int'(count); nop = int'(mode);
            end else begin
              nd = 1;
            end
          end else begin
            do_op = 1; op = int'(mode);
          end
        end else begin
          do_op = 1; op = m_op; nr = m_rem - 1;
          if (nr == 0) begin
            nb = 0; nd = 1;
          end
        end
      end
      if (do_op) begin
        for (int i = 0; i < 2; i++) begin
          m_q[i]  <= model_q(op, m_q[i], i + 1, (i == 0) ? int'(sin1) : int'(sin2), int'(pin));
          m_so[i] <= model_so(op, m_q[i], i + 1, m_so[i]);
        end
      end
      m_busy <= nb; m_rem <= nr; m_op <= nop; m_done <= nd;
    end
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  // ---------------- compare process ----------------
  always @(negedge clk) begin
    if (chk_on) begin
      check("q_step1",    32'(pout1), m_q[0]);
      check("so_step1",   32'(sout1), m_so[0]);
      check("q_step2",    32'(pout2), m_q[1]);
      check("so_step2",   32'(sout2), m_so[1]);
      check("busy",       32'(busy1), m_busy);
      check("done",       32'(done1), m_done);
      check("state_dbg",  32'(st1),   m_busy);
      check("busy_step2", 32'(busy2), m_busy);
      check("done_step2", 32'(done2), m_done);
    end
  end

  // Drive one cycle: inputs change just after negedge, return just after
  // the following negedge (the posedge in between has taken effect).
  task automatic cyc(input logic e, input int md, input int p, input logic s1,
                     input logic [1:0] s2, input logic st, input int cnt);
    en = e; mode = md[2:0]; pin = p[7:0]; sin1 = s1; sin2 = s2;
    start = st; count = cnt[3:0];
    @(negedge clk); #1;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    #1;
    chk_on = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    check("reset_q",    32'(pout1), 0);
    check("reset_so",   32'(sout1), 0);
    check("reset_busy", 32'(busy1), 0);
    check("reset_done", 32'(done1), 0);
    rst = 1'b0;

    // LOAD then SHL
    cyc(1, LOAD, 'hA5, 0, 0, 0, 0);
    check("load_a5", 32'(pout1), 'hA5);
    cyc(1, SHL, 0, 1, 0, 0, 0);
    check("shl_q", 32'(pout1), 'h4B);
    check("shl_so", 32'(sout1), 1);

    // ROR burst of 3 from 0x81; mode/start/count during burst must be ignored
    cyc(1, LOAD, 'h81, 0, 0, 0, 0);
    cyc(1, ROR, 0, 0, 0, 1, 3);
    check("ror_start_q", 32'(pout1), 'h81);
    check("ror_start_busy", 32'(busy1), 1);
    cyc(1, CLR, 'hFF, 1, 3, 1, 9);
    check("ror1_q", 32'(pout1), 'hC0);
    check("ror1_so", 32'(sout1), 1);
    check("ror1_busy", 32'(busy1), 1);
    cyc(1, LOAD, 'hFF, 1, 3, 1, 9);
    check("ror2_q", 32'(pout1), 'h60);
    cyc(1, SHL, 'hFF, 1, 3, 0, 0);
    check("ror3_q", 32'(pout1), 'h30);
    check("ror3_busy", 32'(busy1), 0);
    check("ror3_done", 32'(done1), 1);
    cyc(1, HOLD, 0, 0, 0, 0, 0);
    check("ror_done_clear", 32'(done1), 0);

    // ASR burst of 2 from 0x80
    cyc(1, LOAD, 'h80, 0, 0, 0, 0);
    cyc(1, ASR, 0, 0, 0, 1, 2);
    cyc(1, HOLD, 0, 0, 0, 0, 0);
    check("asr1_q", 32'(pout1), 'hC0);
    cyc(1, HOLD, 0, 0, 0, 0, 0);
    check("asr2_q", 32'(pout1), 'hE0);
    check("asr2_so", 32'(sout1), 0);
    check("asr2_done", 32'(done1), 1);

    // STEP=2 SHR
    cyc(1, LOAD, 'hF0, 0, 0, 0, 0);
    cyc(1, SHR, 0, 0, 2'b01, 0, 0);
    check("step2_shr_q", 32'(pout2), 'h7C);
    check("step2_shr_so", 32'(sout2), 0);

    // Burst of 4 SHL with en low for two cycles; done exactly 6 edges after start
    cyc(1, LOAD, 'h01, 0, 0, 0, 0);
    cyc(1, SHL, 0, 0, 0, 1, 4);
    begin
      logic en_pat[6] = '{1, 1, 0, 0, 1, 1};
      int   q_exp[6]  = '{'h02, 'h04, 'h04, 'h04, 'h08, 'h10};
      for (int k = 0; k < 6; k++) begin
        cyc(en_pat[k], HOLD, 0, 0, 0, 0, 0);
        check("frz_q", 32'(pout1), q_exp[k]);
        check("frz_done", 32'(done1), (k == 5) ? 1 : 0);
        check("frz_busy", 32'(busy1), (k == 5) ? 0 : 1);
      end
    end

    // count=0: done only, q unchanged; start accepted while done is high
    cyc(1, CLR, 0, 0, 0, 1, 0);
    check("cnt0_done", 32'(done1), 1);
    check("cnt0_q", 32'(pout1), 'h10);
    check("cnt0_busy", 32'(busy1), 0);
    cyc(1, ROL, 0, 0, 0, 1, 1);
    check("b2b_busy", 32'(busy1), 1);
    cyc(1, HOLD, 0, 0, 0, 0, 0);
    check("b2b_q", 32'(pout1), 'h20);
    check("b2b_done", 32'(done1), 1);

    // Asynchronous reset mid-burst
    cyc(1, LOAD, 'h55, 0, 0, 0, 0);
    cyc(1, ROL, 0, 0, 0, 1, 5);
    cyc(1, HOLD, 0, 0, 0, 0, 0);
    rst = 1'b1;
    #1;
    check("arst_q", 32'(pout1), 0);
    check("arst_so", 32'(sout1), 0);
    check("arst_busy", 32'(busy1), 0);
    check("arst_done", 32'(done1), 0);
    @(negedge clk); #1;
    rst = 1'b0;
    cyc(1, LOAD, 'h03, 0, 0, 0, 0);
    check("post_rst_load", 32'(pout1), 'h03);
    cyc(1, ROL, 0, 0, 0, 1, 2);
    cyc(1, HOLD, 0, 0, 0, 0, 0);
    check("post_rst_rol1", 32'(pout1), 'h06);
    cyc(1, HOLD, 0, 0, 0, 0, 0);
    check("post_rst_rol2", 32'(pout1), 'h0C);
    check("post_rst_done", 32'(done1), 1);

    // Randomized phase, checked by the compare process against the model
    for (int n = 0; n < 1500; n++) begin
      int cnt;
      cnt = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 15)) : int'($urandom_range(0, 4));
      rst = ($urandom_range(0, 119) == 0);
      cyc($urandom_range(0, 99) < 85, int'($urandom_range(0, 7)), int'($urandom_range(0, 255)),
          1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
          $urandom_range(0, 99) < 30, cnt);
    end
    rst = 1'b0;
    cyc(0, HOLD, 0, 0, 0, 0, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    n_errors++;
    $display("FAIL timeout: simulation did not complete");
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/universal_shift_register.md
UNIVERSAL_SHIFT_REGISTER -- requirements
Module: universal_shift_register

Interface
REQ-001 Parameter WIDTH, default 8; register width in bits, SHALL be >= 2.
REQ-002 Parameter STEP, default 1; bits moved per shift or rotate, SHALL be 1..WIDTH-1.
REQ-003 Parameter CNT_W, default 4; width of the burst count.
REQ-004 clk  in  1  sole clock; all state changes on its rising edge.
REQ-005 rst  in  1  reset, asynchronous, active-high.
REQ-006 en  in  1  clock enable; en=0 SHALL freeze q, burst state and serial_out.
REQ-007 mode  in  3  operation: 000 HOLD, 001 LOAD, 010 SHL, 011 SHR, 100 ROL, 101 ROR, 110 ASR, 111 CLR.
REQ-008 parallel_in  in  WIDTH  load data.
REQ-009 serial_in  in  STEP  bits entering on SHL (at LSBs) or SHR (at MSBs).
REQ-010 start  in  1  burst request.
REQ-011 count  in  CNT_W  number of burst operations.
REQ-012 parallel_out  out  WIDTH  register contents q.
REQ-013 serial_out  out  STEP  registered bits ejected by the most recent SHL/SHR/ROL/ROR/ASR.
REQ-014 busy  out  1  burst in progress.
REQ-015 done  out  1  one-cycle burst-complete pulse.

Function
REQ-016 Operations (q = current register): HOLD q; LOAD parallel_in; SHL {q[WIDTH-STEP-1:0],serial_in}; SHR {serial_in,q[WIDTH-1:STEP]}; ROL/ROR rotate by STEP; ASR q shifted right by STEP with the MSB replicated; CLR all zeros.
REQ-017 serial_out SHALL update to q[WIDTH-1 -: STEP] on SHL/ROL, q[STEP-1:0] on SHR/ROR/ASR, and SHALL hold on HOLD/LOAD/CLR.
REQ-018 Direct mode (IDLE, start=0, en=1): mode SHALL be applied once per edge, with latency 1 cycle to parallel_out.
REQ-019 States: IDLE and BUSY; busy=1 exactly in BUSY.
REQ-020 IDLE with en=1, start=1, count>0: the edge SHALL capture mode, load remaining counter rem=count, enter BUSY, and leave q unchanged.
REQ-021 IDLE with en=1, start=1, count=0: the block SHALL stay IDLE, leave q unchanged, and pulse done on the next cycle.
REQ-022 BUSY with en=1: each edge SHALL apply the captured mode with the live serial_in and decrement rem.
REQ-023 On the edge where rem reaches 0: BUSY->IDLE, busy=0, done=1 for exactly one cycle; N operations complete N edges after the start edge.
REQ-024 In BUSY, the mode, start and count inputs SHALL be ignored.
REQ-025 BUSY with en=0: no operation, rem held, busy held.
REQ-026 done SHALL clear on the following edge regardless of en.
REQ-027 A start in the same cycle that done is high SHALL be accepted (back-to-back bursts).
REQ-028 Burst of LOAD, HOLD or CLR SHALL be legal; the operation is repeated count times.
REQ-029 rem SHALL never underflow or wrap.

Reset
REQ-030 rst=1 SHALL immediately, independent of clk, force q=0, serial_out=0, busy=0, done=0, rem=0, state IDLE.
REQ-031 Reset mid-burst SHALL abort the burst with no done pulse.
REQ-032 The first edge after rst falls SHALL accept a start or direct operation normally.

Verification (WIDTH=8 unless noted)
REQ-033 LOAD parallel_in=0xA5, then SHL serial_in=1 -> 0xA5, then 0x4B, serial_out=1.
REQ-034 q=0x81, start, count=3, mode=ROR -> 0xC0, 0x60, 0x30 on successive edges; busy high 3 cycles; done high 1 cycle, coincident with busy falling.
REQ-035 q=0x80, burst ASR count=2 -> 0xC0 then 0xE0; serial_out=0.
REQ-036 STEP=2: q=0xF0, SHR serial_in=2'b01 -> 0x7C, serial_out=2'b00.
REQ-037 Burst count=4 with en=0 for 2 cycles mid-burst -> q and rem frozen; done 6 cycles after start; count=0 -> done only, q unchanged.
REQ-038 rst asserted between clock edges during a burst -> all outputs 0 before the next edge; new burst after release completes correctly.
